// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : parity_calc
//  Description : Parity generator (combinational) and registered parity
//                checker with a saturating error counter for the UPDI UART
//                byte path.
//  Revision    : 1.0  initial release
// ============================================================================
module parity_calc #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // transmit-side generator
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  parity,
    // receive-side checker
    input  logic                  chk_valid,
    input  logic [DATA_WIDTH-1:0] chk_data,
    input  logic                  chk_bit,
    output logic                  chk_done,
    output logic                  chk_err,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    input  logic                  err_clr
);

    localparam logic                 c_ODD_BIT = (ODD_PARITY != 0);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    logic                 w_exp_parity;
    logic                 w_mismatch;

    logic                 chk_done_d, chk_done_q;
    logic                 chk_err_d,  chk_err_q;
    logic [CNT_WIDTH-1:0] err_cnt_d,  err_cnt_q;

    // Reduction XOR passes X/Z straight through, so unknown inputs stay visible.
    assign parity       = (^value) ^ c_ODD_BIT;

    assign w_exp_parity = (^chk_data) ^ c_ODD_BIT;
    assign w_mismatch   = (w_exp_parity != chk_bit);

    always_comb begin
        chk_done_d = chk_valid;
        chk_err_d  = chk_err_q;
        err_cnt_d  = err_cnt_q;

        if (chk_valid) begin
            chk_err_d = w_mismatch;
        end

        // Clear wins over a coincident error; the counter never wraps.
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (chk_valid && w_mismatch && (err_cnt_q != c_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_done_q <= 1'b0;
            chk_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            chk_done_q <= chk_done_d;
            chk_err_q  <= chk_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign chk_done = chk_done_q;
    assign chk_err  = chk_err_q;
    assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_calc
//  Description : Self-checking bench for parity_calc; an even-parity/8-bit
//                counter instance and an odd-parity/2-bit counter instance
//                share one stimulus stream and are compared to a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_parity_calc;

    logic       clk;
    logic       rst_n;
    logic [7:0] value;
    logic       chk_valid;
    logic [7:0] chk_data;
    logic       chk_bit;
    logic       err_clr;

    logic       parity0, parity1;
    logic       chk_done0, chk_done1;
    logic       chk_err0, chk_err1;
    logic [7:0] err_cnt0;
    logic [1:0] err_cnt1;

    int n_checks;
    int n_errors;

    // Reference model state, index 0 = even/8-bit, index 1 = odd/2-bit
    bit m_done [2];
    bit m_err  [2];
    int m_cnt  [2];
    int c_max  [2] = '{255, 3};
    bit c_odd  [2] = '{1'b0, 1'b1};

    parity_calc #(.DATA_WIDTH(8), .ODD_PARITY(0), .CNT_WIDTH(8)) u_dut_even (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .parity    (parity0),
        .chk_valid (chk_valid),
        .chk_data  (chk_data),
        .chk_bit   (chk_bit),
        .chk_done  (chk_done0),
        .chk_err   (chk_err0),
        .err_cnt   (err_cnt0),
        .err_clr   (err_clr)
    );

    parity_calc #(.DATA_WIDTH(8), .ODD_PARITY(1), .CNT_WIDTH(2)) u_dut_odd (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .parity    (parity1),
        .chk_valid (chk_valid),
        .chk_data  (chk_data),
        .chk_bit   (chk_bit),
        .chk_done  (chk_done1),
        .chk_err   (chk_err1),
        .err_cnt   (err_cnt1),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Parity from the count of ones: even count -> 0 for even parity.
    function automatic bit ref_par(input logic [7:0] v, input bit odd);
        return ((($countones(v) % 2) == 1) ? 1'b1 : 1'b0) ^ odd;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 1'b0;
            m_err[k]  = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".done0"}, 32'(chk_done0), 32'(m_done[0]));
        check({tag, ".err0"},  32'(chk_err0),  32'(m_err[0]));
        check({tag, ".cnt0"},  32'(err_cnt0),  32'(m_cnt[0]));
        check({tag, ".done1"}, 32'(chk_done1), 32'(m_done[1]));
        check({tag, ".err1"},  32'(chk_err1),  32'(m_err[1]));
        check({tag, ".cnt1"},  32'(err_cnt1),  32'(m_cnt[1]));
    endtask

    // Called just after a negedge: drive, cross one rising edge, compare.
    task automatic step(input string tag, input bit v, input logic [7:0] d,
                        input bit b, input bit clr);
        bit bad;
        chk_valid = v;
        chk_data  = d;
        chk_bit   = b;
        err_clr   = clr;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bad       = (ref_par(d, c_odd[k]) != b);
            m_done[k] = v;
            if (v) m_err[k] = bad;
            if (clr)
                m_cnt[k] = 0;
            else if (v && bad && m_cnt[k] < c_max[k])
                m_cnt[k] = m_cnt[k] + 1;
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] gen_vals [6] = '{8'hFF, 8'h00, 8'hAA, 8'h91, 8'h10, 8'h7F};
        bit         gen_exp  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        value     = 8'h00;
        chk_valid = 1'b0;
        chk_data  = 8'h00;
        chk_bit   = 1'b0;
        err_clr   = 1'b0;
        model_reset();

        // Generator directed values while reset is held
        for (int i = 0; i < 6; i++) begin
            value = gen_vals[i];
            #1;
            check("gen_dir_even", 32'(parity0), 32'(gen_exp[i]));
            check("gen_dir_odd",  32'(parity1), 32'(!gen_exp[i]));
        end
        // Exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            value = 8'(i);
            #1;
            check("gen_sweep_even", 32'(parity0), 32'(ref_par(8'(i), 1'b0)));
            check("gen_sweep_odd",  32'(parity1), 32'(ref_par(8'(i), 1'b1)));
        end

        @(negedge clk);
        compare_all("reset");
        #2 rst_n = 1'b1;
        @(negedge clk);
        step("idle0", 1'b0, 8'h00, 1'b0, 1'b0);
        step("idle1", 1'b0, 8'h00, 1'b0, 1'b0);

        // Directed plan
        step("good",     1'b1, 8'h91, 1'b1, 1'b0);
        check("good_err0_abs", 32'(chk_err0), 32'd0);
        step("good_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("bad",      1'b1, 8'hAA, 1'b1, 1'b0);
        check("bad_cnt0_abs", 32'(err_cnt0), 32'd1);
        step("bad_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        check("bad_idle_err0_hold", 32'(chk_err0), 32'd1);
        step("b2b_a",    1'b1, 8'h10, 1'b0, 1'b0);
        step("b2b_b",    1'b1, 8'h7F, 1'b1, 1'b0);
        step("b2b_c",    1'b1, 8'h00, 1'b1, 1'b0);
        check("b2b_cnt0_abs", 32'(err_cnt0), 32'd3);

        // Saturation on the 2-bit odd instance: 0xAA with bit 0 is bad for odd parity
        step("sat_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("sat", 1'b1, 8'hAA, 1'b0, 1'b0);
            check("sat_cnt1_abs", 32'(err_cnt1), 32'((i < 3) ? i + 1 : 3));
        end
        step("clr_vs_err", 1'b1, 8'hAA, 1'b0, 1'b1);
        check("clr_vs_err_cnt1_abs", 32'(err_cnt1), 32'd0);
        check("clr_vs_err_err1_abs", 32'(chk_err1), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom), 1'($urandom_range(0, 15) == 0));
        end

        // Build up errors, then reset asynchronously in the middle of a strobe
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 8'h01, 1'b0, 1'b0);
        chk_valid = 1'b1;
        chk_data  = 8'h01;
        chk_bit   = 1'b0;
        #2 rst_n  = 1'b0;
        model_reset();
        #1 compare_all("async_rst_now");
        @(posedge clk);
        @(negedge clk);
        compare_all("async_rst_held");
        chk_valid = 1'b0;
        #2 rst_n  = 1'b1;
        @(negedge clk);
        step("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        step("post_rst_bad",  1'b1, 8'h01, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
